// File: rtl/hr_seq_pkg.sv
// Shared constants and state encoding for the HyperRAM local-bus block sequencer.
package hr_seq_pkg;

    // Local-bus register map of the HyperRAM controller
    localparam logic [31:0] REG_ADDR  = 32'h0000_0010;
    localparam logic [31:0] REG_WDATA = 32'h0000_0014;
    localparam logic [31:0] REG_CMD   = 32'h0000_001c;

    // Command register opcodes
    localparam logic [31:0] CMD_WRITE = 32'h0000_0001;
    localparam logic [31:0] CMD_READ  = 32'h0000_0004;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        StIdle      = 4'd0,
        StStart     = 4'd1,
        StFetch     = 4'd2,
        StSetAddr   = 4'd3,
        StSetData   = 4'd4,
        StIssue     = 4'd5,
        StWaitHi    = 4'd6,
        StWaitLo    = 4'd7,
        StWaitRdy   = 4'd8,
        StWaitRdyLo = 4'd9,
        StOut       = 4'd10,
        StNext      = 4'd11,
        StDone      = 4'd12
    } hr_state_e;

    // States that wait on the RAM and are therefore guarded by the timeout
    function automatic logic is_wait_state(input hr_state_e s);
        return (s == StWaitHi) || (s == StWaitLo) || (s == StWaitRdy) || (s == StWaitRdyLo);
    endfunction

endpackage

// File: rtl/hr_wait_timer.sv
// Cycle counter guarding the RAM wait states; flags the TIMEOUT_CYC-th enabled cycle.
module hr_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // The current enabled cycle is the TIMEOUT_CYC-th one spent waiting
    assign o_expired = i_enable && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Count enabled cycles, saturating; clear wins over counting
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_W'(TIMEOUT_CYC))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hr_lb_sequencer.sv
// Block-transfer engine: turns one (base, len, dir) command into per-word
// HyperRAM local-bus register sequences, streaming data in or out.
module hr_lb_sequencer
    import hr_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned LEN_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_cmd_start,
    input  logic             i_cmd_dir,
    input  logic [31:0]      i_cmd_base,
    input  logic [LEN_W-1:0] i_cmd_len,
    output logic             o_cmd_busy,
    output logic             o_cmd_done,
    output logic             o_cmd_err,
    input  logic [31:0]      i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready,
    output logic             o_lb_wr,
    output logic             o_lb_rd,
    output logic [31:0]      o_lb_addr,
    output logic [31:0]      o_lb_wr_d,
    input  logic [31:0]      i_lb_rd_d,
    input  logic             i_lb_rd_rdy,
    input  logic             i_hyperram_busy
);

    hr_state_e        r_state;
    hr_state_e        w_state_nxt;
    logic             r_dir;
    logic [31:0]      r_base;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rd_data;
    logic             r_err;

    logic             w_accept;
    logic [LEN_W-1:0] w_idx_inc;
    logic             w_tmr_clr;
    logic             w_tmr_en;
    logic             w_expired;
    logic             w_timeout;
    logic             w_wr_ready;
    logic             w_rd_valid;
    logic             w_lb_wr;
    logic [31:0]      w_lb_addr;
    logic [31:0]      w_lb_wr_d;

    assign w_accept  = (r_state == StIdle) && i_cmd_start;
    assign w_idx_inc = r_idx + 1'b1;

    // Counter restarts whenever a wait state is freshly entered
    assign w_tmr_clr = is_wait_state(w_state_nxt) && (w_state_nxt != r_state);
    assign w_tmr_en  = is_wait_state(r_state);

    hr_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_tmr_clr),
        .i_enable  (w_tmr_en),
        .o_expired (w_expired)
    );

    // State register plus command, index and data capture
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_dir     <= 1'b0;
            r_base    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_dir  <= i_cmd_dir;
                r_base <= i_cmd_base;
                r_len  <= i_cmd_len;
                r_idx  <= '0;
                r_err  <= 1'b0;
            end
            if ((r_state == StFetch) && i_wr_valid) begin
                r_wdata <= i_wr_data;
            end
            // Only the first rdy cycle reaches here; a held level is absorbed in StWaitRdyLo
            if ((r_state == StWaitRdy) && i_lb_rd_rdy) begin
                r_rd_data <= i_lb_rd_d;
            end
            if (r_state == StNext) begin
                r_idx <= w_idx_inc;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next-state decode and per-state bus/stream outputs
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_wr_ready  = 1'b0;
        w_rd_valid  = 1'b0;
        w_lb_wr     = 1'b0;
        w_lb_addr   = '0;
        w_lb_wr_d   = '0;
        unique case (r_state)
            StIdle: begin
                if (i_cmd_start) w_state_nxt = StStart;
            end
            StStart: begin
                if (r_len == '0) w_state_nxt = StDone;
                else             w_state_nxt = r_dir ? StSetAddr : StFetch;
            end
            StFetch: begin
                w_wr_ready = 1'b1;
                if (i_wr_valid) w_state_nxt = StSetAddr;
            end
            StSetAddr: begin
                w_lb_wr     = 1'b1;
                w_lb_addr   = REG_ADDR;
                w_lb_wr_d   = r_base + 32'(r_idx);
                w_state_nxt = r_dir ? StIssue : StSetData;
            end
            StSetData: begin
                w_lb_wr     = 1'b1;
                w_lb_addr   = REG_WDATA;
                w_lb_wr_d   = r_wdata;
                w_state_nxt = StIssue;
            end
            StIssue: begin
                w_lb_wr     = 1'b1;
                w_lb_addr   = REG_CMD;
                w_lb_wr_d   = r_dir ? CMD_READ : CMD_WRITE;
                w_state_nxt = r_dir ? StWaitRdy : StWaitHi;
            end
            // busy may lag ISSUE, so low busy here means "not started yet"
            StWaitHi: begin
                if (i_hyperram_busy) begin
                    w_state_nxt = StWaitLo;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StWaitLo: begin
                if (!i_hyperram_busy) begin
                    w_state_nxt = StNext;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StWaitRdy: begin
                if (i_lb_rd_rdy) begin
                    w_state_nxt = StWaitRdyLo;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StWaitRdyLo: begin
                if (!i_lb_rd_rdy && !i_hyperram_busy) begin
                    w_state_nxt = StOut;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StOut: begin
                w_rd_valid = 1'b1;
                if (i_rd_ready) w_state_nxt = StNext;
            end
            StNext: begin
                if (w_idx_inc == r_len) w_state_nxt = StDone;
                else                    w_state_nxt = r_dir ? StSetAddr : StFetch;
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign o_cmd_busy = (r_state != StIdle) && (r_state != StDone);
    assign o_cmd_done = (r_state == StDone);
    assign o_cmd_err  = r_err;
    assign o_wr_ready = w_wr_ready;
    assign o_rd_valid = w_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_lb_wr    = w_lb_wr;
    assign o_lb_rd    = 1'b0;
    assign o_lb_addr  = w_lb_addr;
    assign o_lb_wr_d  = w_lb_wr_d;

endmodule

// File: tb/tb_hr_lb_sequencer.sv
// Scoreboard bench for hr_lb_sequencer with a behavioural HyperRAM register model.
module tb_hr_lb_sequencer;

    localparam int unsigned LEN_W       = 16;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic             clk;
    logic             reset;
    logic             cmd_start;
    logic             cmd_dir;
    logic [31:0]      cmd_base;
    logic [LEN_W-1:0] cmd_len;
    logic             o_cmd_busy;
    logic             o_cmd_done;
    logic             o_cmd_err;
    logic [31:0]      wr_data;
    logic             wr_valid;
    logic             o_wr_ready;
    logic [31:0]      o_rd_data;
    logic             o_rd_valid;
    logic             rd_ready;
    logic             o_lb_wr;
    logic             o_lb_rd;
    logic [31:0]      o_lb_addr;
    logic [31:0]      o_lb_wr_d;
    logic [31:0]      lb_rd_d;
    logic             lb_rd_rdy;
    logic             hr_busy;

    int n_total;
    int n_bad;
    int lb_cnt;
    int done_cnt;
    int rd_cnt;
    int cyc_cnt;
    int issue_cyc;
    bit stuck;
    int sink_delay;

    logic [63:0] exp_lb[$];
    logic [31:0] exp_rd[$];
    logic [31:0] src_q[$];
    logic [31:0] mem[logic [31:0]];

    logic        prev_valid;
    logic        prev_xfer;
    logic [31:0] prev_data;

    hr_lb_sequencer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LEN_W       (LEN_W)
    ) u_dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_cmd_start     (cmd_start),
        .i_cmd_dir       (cmd_dir),
        .i_cmd_base      (cmd_base),
        .i_cmd_len       (cmd_len),
        .o_cmd_busy      (o_cmd_busy),
        .o_cmd_done      (o_cmd_done),
        .o_cmd_err       (o_cmd_err),
        .i_wr_data       (wr_data),
        .i_wr_valid      (wr_valid),
        .o_wr_ready      (o_wr_ready),
        .o_rd_data       (o_rd_data),
        .o_rd_valid      (o_rd_valid),
        .i_rd_ready      (rd_ready),
        .o_lb_wr         (o_lb_wr),
        .o_lb_rd         (o_lb_rd),
        .o_lb_addr       (o_lb_addr),
        .o_lb_wr_d       (o_lb_wr_d),
        .i_lb_rd_d       (lb_rd_d),
        .i_lb_rd_rdy     (lb_rd_rdy),
        .i_hyperram_busy (hr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] a_word(input int i);
        return 32'hCAFE_00A0 + 32'(i);
    endfunction

    function automatic logic [63:0] out_sig();
        return {25'b0, o_cmd_busy, o_cmd_done, o_cmd_err, o_wr_ready, o_rd_valid, o_lb_wr,
                o_lb_rd, o_lb_addr | o_lb_wr_d | o_rd_data};
    endfunction

    task automatic start_cmd(input logic dir, input logic [31:0] base,
                             input logic [LEN_W-1:0] len);
        cmd_dir   = dir;
        cmd_base  = base;
        cmd_len   = len;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    // Cycles counted from the accepting edge; leaves one cycle past DONE
    task automatic wait_done(input int max_cyc, output int cyc, output int at_cyc);
        cyc = 1;
        while (!o_cmd_done && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        check_val("done_seen", 64'(o_cmd_done), 64'd1);
        at_cyc = cyc_cnt;
        tick();
        check_val("done_pulse", 64'(o_cmd_done), 64'd0);
    endtask

    // Bus/stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (o_lb_wr) begin
                lb_cnt++;
                if (o_lb_addr == 32'h1c) issue_cyc = cyc_cnt;
                check_val("lb_rd", 64'(o_lb_rd), 64'd0);
                if (exp_lb.size() == 0) check_val("lb_extra", 64'(o_lb_wr), 64'd0);
                else check_val("lb_seq", {o_lb_addr, o_lb_wr_d}, exp_lb.pop_front());
            end else begin
                check_val("lb_idle", {o_lb_addr, o_lb_wr_d}, 64'd0);
            end
            if (o_rd_valid && prev_valid && !prev_xfer)
                check_val("rd_stable", 64'(o_rd_data), 64'(prev_data));
            if (o_rd_valid && rd_ready) begin
                rd_cnt++;
                if (exp_rd.size() == 0) check_val("rd_extra", 64'(o_rd_valid), 64'd0);
                else check_val("rd_data", 64'(o_rd_data), 64'(exp_rd.pop_front()));
            end
            if (o_cmd_done) begin
                done_cnt++;
                check_val("done_busy", 64'(o_cmd_busy), 64'd0);
            end
        end
        prev_valid = o_rd_valid;
        prev_xfer  = o_rd_valid && rd_ready;
        prev_data  = o_rd_data;
    end

    // HyperRAM model: latches addr/data, runs a randomly timed busy window per ISSUE
    initial begin : ram_model
        logic [31:0] ram_addr;
        logic [31:0] ram_wd;
        bit          is_rd;
        hr_busy   = 1'b0;
        lb_rd_rdy = 1'b0;
        lb_rd_d   = '0;
        ram_addr  = '0;
        ram_wd    = '0;
        forever begin
            @(negedge clk);
            if (!reset && o_lb_wr) begin
                if (o_lb_addr == 32'h10) begin
                    ram_addr = o_lb_wr_d;
                end else if (o_lb_addr == 32'h14) begin
                    ram_wd = o_lb_wr_d;
                end else if (o_lb_addr == 32'h1c && !stuck) begin
                    is_rd = (o_lb_wr_d == 32'h4);
                    tick();
                    repeat ($urandom_range(0, 2)) tick();
                    hr_busy = 1'b1;
                    repeat ($urandom_range(2, 10)) tick();
                    hr_busy = 1'b0;
                    if (is_rd) begin
                        lb_rd_d   = mem.exists(ram_addr) ? mem[ram_addr] : 32'hBAD0_BAD0;
                        lb_rd_rdy = 1'b1;
                        repeat ($urandom_range(1, 3)) tick();
                        lb_rd_rdy = 1'b0;
                        lb_rd_d   = '0;
                    end else begin
                        mem[ram_addr] = ram_wd;
                    end
                end
            end
        end
    end

    // Write-stream source fed from src_q
    initial begin : wr_source
        wr_valid = 1'b0;
        wr_data  = '0;
        forever begin
            @(negedge clk);
            if (!reset && wr_valid && o_wr_ready) void'(src_q.pop_front());
            tick();
            if (src_q.size() != 0) begin
                wr_valid = 1'b1;
                wr_data  = src_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = '0;
            end
        end
    end

    // Read-stream sink: holds ready low for sink_delay cycles of each valid word
    initial begin : rd_sink
        int vcnt;
        vcnt     = 0;
        rd_ready = 1'b0;
        forever begin
            tick();
            if (o_rd_valid && !rd_ready) begin
                vcnt++;
                if (vcnt > sink_delay) rd_ready = 1'b1;
            end else begin
                rd_ready = 1'b0;
                vcnt     = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int cyc;
        int at;
        int d0;
        int l0;
        int r0;
        int k;
        n_total = 0; n_bad = 0; lb_cnt = 0; done_cnt = 0; rd_cnt = 0;
        cyc_cnt = 0; issue_cyc = 0; stuck = 1'b0; sink_delay = 5;
        prev_valid = 1'b0; prev_xfer = 1'b0; prev_data = '0;
        reset = 1'b1; cmd_start = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
        repeat (3) tick();
        check_val("rst_outs", out_sig(), 64'd0);
        reset = 1'b0;
        tick();
        check_val("idle_outs", out_sig(), 64'd0);

        // Write three words at 0x20
        for (int i = 0; i < 3; i++) begin
            exp_lb.push_back({32'h10, 32'(32'h20 + i)});
            exp_lb.push_back({32'h14, a_word(i)});
            exp_lb.push_back({32'h1c, 32'h1});
            src_q.push_back(a_word(i));
        end
        d0 = done_cnt;
        start_cmd(1'b0, 32'h20, 16'd3);
        check_val("t1_busy", 64'(o_cmd_busy), 64'd1);
        wait_done(400, cyc, at);
        check_val("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_val("t1_err", 64'(o_cmd_err), 64'd0);
        check_val("t1_lb_left", 64'(exp_lb.size()), 64'd0);

        // Read them back with a slow sink
        for (int i = 0; i < 3; i++) begin
            exp_lb.push_back({32'h10, 32'(32'h20 + i)});
            exp_lb.push_back({32'h1c, 32'h4});
            exp_rd.push_back(a_word(i));
        end
        d0 = done_cnt; r0 = rd_cnt;
        start_cmd(1'b1, 32'h20, 16'd3);
        wait_done(600, cyc, at);
        check_val("t2_rd_cnt", 64'(rd_cnt - r0), 64'd3);
        check_val("t2_rd_left", 64'(exp_rd.size()), 64'd0);
        check_val("t2_lb_left", 64'(exp_lb.size()), 64'd0);
        check_val("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_val("t2_err", 64'(o_cmd_err), 64'd0);

        // Zero-length command
        d0 = done_cnt; l0 = lb_cnt;
        start_cmd(1'b0, 32'h55, 16'd0);
        wait_done(20, cyc, at);
        check_val("t3_done_lat", 64'(cyc), 64'd2);
        check_val("t3_lb_cnt", 64'(lb_cnt - l0), 64'd0);
        check_val("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Busy never rises: timeout
        stuck = 1'b1;
        exp_lb.push_back({32'h10, 32'h40});
        exp_lb.push_back({32'h14, 32'h1234_5678});
        exp_lb.push_back({32'h1c, 32'h1});
        src_q.push_back(32'h1234_5678);
        d0 = done_cnt;
        start_cmd(1'b0, 32'h40, 16'd1);
        wait_done(200, cyc, at);
        check_val("t4_err", 64'(o_cmd_err), 64'd1);
        check_val("t4_to_lat", 64'(at - issue_cyc), 64'd17);
        check_val("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_val("t4_lb_left", 64'(exp_lb.size()), 64'd0);
        stuck = 1'b0;

        // Address wrap; start also clears the sticky error
        exp_lb.push_back({32'h10, 32'hFFFF_FFFF});
        exp_lb.push_back({32'h14, 32'hB0B0_0000});
        exp_lb.push_back({32'h1c, 32'h1});
        exp_lb.push_back({32'h10, 32'h0000_0000});
        exp_lb.push_back({32'h14, 32'hB0B0_0001});
        exp_lb.push_back({32'h1c, 32'h1});
        src_q.push_back(32'hB0B0_0000);
        src_q.push_back(32'hB0B0_0001);
        d0 = done_cnt;
        start_cmd(1'b0, 32'hFFFF_FFFF, 16'd2);
        check_val("t5_err_clr", 64'(o_cmd_err), 64'd0);
        wait_done(400, cyc, at);
        check_val("t5_err", 64'(o_cmd_err), 64'd0);
        check_val("t5_lb_left", 64'(exp_lb.size()), 64'd0);
        check_val("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Second start while busy, then reset during WAIT_LO
        exp_lb.push_back({32'h10, 32'h80});
        exp_lb.push_back({32'h14, 32'hC0C0_0000});
        exp_lb.push_back({32'h1c, 32'h1});
        src_q.push_back(32'hC0C0_0000);
        src_q.push_back(32'hC0C0_0001);
        d0 = done_cnt;
        start_cmd(1'b0, 32'h80, 16'd2);
        start_cmd(1'b1, 32'h999, 16'd5);
        k = 0;
        while (!hr_busy && k < 100) begin
            tick();
            k++;
        end
        check_val("t6_busy_rise", 64'(hr_busy), 64'd1);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_async_rst", out_sig(), 64'd0);
        repeat (3) tick();
        src_q.delete();
        tick();
        reset = 1'b0;
        check_val("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("t6_lb_left", 64'(exp_lb.size()), 64'd0);
        k = 0;
        while (hr_busy && k < 50) begin
            tick();
            k++;
        end
        repeat (2) tick();

        // Clean command after reset
        exp_lb.push_back({32'h10, 32'h21});
        exp_lb.push_back({32'h1c, 32'h4});
        exp_rd.push_back(a_word(1));
        d0 = done_cnt; r0 = rd_cnt;
        start_cmd(1'b1, 32'h21, 16'd1);
        wait_done(300, cyc, at);
        check_val("t7_rd_cnt", 64'(rd_cnt - r0), 64'd1);
        check_val("t7_rd_left", 64'(exp_rd.size()), 64'd0);
        check_val("t7_lb_left", 64'(exp_lb.size()), 64'd0);
        check_val("t7_done_cnt", 64'(done_cnt - d0), 64'd1);
        check_val("t7_err", 64'(o_cmd_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hr_lb_sequencer.md
Name: hr_lb_sequencer

Overview:
- Block-transfer engine directly upstream of the HyperRAM local-bus register interface; it drives lb_wr/lb_addr/lb_wr_d and consumes hyperram_busy, lb_rd_rdy and lb_rd_d.
- Converts one command (base word address, length, direction) into per-word register sequences.
- Write direction: streams words in from a valid/ready source.
- Read direction: streams words out to a valid/ready sink.
- Used by capture logic to dump and retrieve trace buffers without CPU register pokes.

Parameters:
- TIMEOUT_CYC, 1024: maximum cycles spent in any wait state before abort.
- LEN_W, 16: width of cmd_len.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  single-cycle pulse; ignored while cmd_busy=1
- cmd_dir  in  1  0 = write to RAM, 1 = read from RAM
- cmd_base  in  32  first word address
- cmd_len  in  LEN_W  number of words
- cmd_busy  out  1  high from the cycle after an accepted start until done
- cmd_done  out  1  one-cycle pulse at end of command
- cmd_err  out  1  sticky timeout flag; cleared by the next accepted cmd_start
- wr_data  in  32  write-stream data
- wr_valid  in  1  write-stream valid
- wr_ready  out  1  write-stream ready
- rd_data  out  32  read-stream data
- rd_valid  out  1  read-stream valid
- rd_ready  in  1  read-stream ready
- lb_wr  out  1  register write strobe
- lb_rd  out  1  register read strobe; tied 0
- lb_addr  out  32  register address
- lb_wr_d  out  32  register write data
- lb_rd_d  in  32  read data
- lb_rd_rdy  in  1  read data valid; level held ≥1 cycle
- hyperram_busy  in  1  HyperRAM operation in progress

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, cmd_err 0.
- IDLE: on cmd_start, latch base/len/dir, clear cmd_err, set cmd_busy next cycle.
  - len = 0: go to DONE with no bus traffic.
- Write path: FETCH → SET_ADDR → SET_DATA → ISSUE → WAIT_HI → WAIT_LO → NEXT.
  - FETCH: wr_ready=1 only in FETCH; transfer occurs when wr_valid & wr_ready; data latched.
  - SET_ADDR: lb_wr=1, lb_addr=0x10, lb_wr_d=base+index (32-bit wrap).
  - SET_DATA: lb_wr=1, lb_addr=0x14, lb_wr_d=latched word.
  - ISSUE: lb_wr=1, lb_addr=0x1c, lb_wr_d=0x1.
  - Each lb_wr strobe lasts exactly one cycle; lb_addr/lb_wr_d are 0 when lb_wr=0.
- Read path: SET_ADDR → ISSUE (lb_wr_d=0x4) → WAIT_RDY → WAIT_RDY_LO → OUT → NEXT.
  - WAIT_RDY: on the first cycle lb_rd_rdy=1, capture lb_rd_d into rd_data.
  - WAIT_RDY_LO: wait until lb_rd_rdy=0 and hyperram_busy=0. A held rdy level yields exactly one captured word.
  - OUT: rd_valid=1 and rd_data stable until rd_ready; transfer occurs on rd_valid & rd_ready, then go to NEXT.
- WAIT_HI: busy may rise 1+ cycles after ISSUE; never treat busy=0 immediately after ISSUE as completion. Wait for busy=1, then WAIT_LO waits for busy=0.
- NEXT: index++. If index==len go to DONE, else go to FETCH (write) or SET_ADDR (read).
- DONE: cmd_done=1 for one cycle, cmd_busy=0 in the same cycle, then IDLE.
- Timeout:
  - Shared counter cleared on entry to WAIT_HI, WAIT_LO, WAIT_RDY or WAIT_RDY_LO.
  - Reaching TIMEOUT_CYC sets cmd_err and goes to DONE.
  - FETCH and OUT never time out, since the stream partner may stall indefinitely.
- Asynchronous reset mid-command: immediate return to IDLE, no cmd_done pulse, partial data discarded.
- cmd_start while busy: no effect on any state.

Decomposition:
- Package hr_seq_pkg:
  - register constants REG_ADDR=0x10, REG_WDATA=0x14, REG_CMD=0x1c, CMD_WRITE=0x1, CMD_READ=0x4
  - state encoding localparams
- Sub-module hr_wait_timer (clear, enable, expired; width clog2(TIMEOUT_CYC+1)).

Test Plan:
- Write base=0x20, len=3, data A0/A1/A2, HyperRAM model with random 2–10 cycle busy:
  - required: lb sequences 0x10←0x20/0x14←A0/0x1c←1, then same for 0x21, 0x22
  - required: one cmd_done, cmd_err=0
- Read back base=0x20, len=3 with rd_ready held low 5 cycles per word:
  - required: rd_data A0, A1, A2 in order, one word per rdy pulse, no duplicates
- len=0 start:
  - required: cmd_done exactly 2 cycles after cmd_start, zero lb_wr strobes
- hyperram_busy stuck 0 after ISSUE, TIMEOUT_CYC=16:
  - required: cmd_err=1 and cmd_done ~17 cycles after ISSUE
  - required: next cmd_start clears cmd_err
- Base=0xFFFFFFFF, len=2:
  - required: addresses 0xFFFFFFFF then 0x00000000
- Second cmd_start during busy, then reset asserted mid WAIT_LO:
  - required: second start ignored
  - required: reset gives all outputs 0 asynchronously, no cmd_done, clean new command afterwards
